// File: rtl/mem_arb_pkg.sv
// Shared definitions for the register-memory arbiter.
//   state_e      : arbiter sequencer states
//   PORT_A/PORT_B: requester index (A = CPU core, B = loader/debug)
package mem_arb_pkg;

  localparam int unsigned DEFAULT_REGISTER_WIDTH       = 4;
  localparam int unsigned DEFAULT_MEMORY_ADDRESS_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle for one arbiter port.
//   req/we/addr/wdata : request, held stable until gnt
//   gnt               : one-cycle grant pulse
//   rvalid/rdata      : one-cycle read response, rdata holds between reads
// master = requester, slave = arbiter.
interface mem_arbiter_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 4
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Combinational two-way winner select.
//   req        : {B, A} request vector
//   last_grant : port granted most recently
//   lock_owner : loader holds the memory, only B is eligible
//   valid_c    : some eligible request exists
//   sel_c      : winning port index
module rr_arbiter_2
  import mem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock_owner,
  output logic       valid_c,
  output logic       sel_c
);

  logic [1:0] eligible;

  always_comb begin
    eligible = req;
    if (lock_owner) begin
      eligible = req & 2'b10;
    end
    valid_c = |eligible;
    sel_c   = PORT_A;
    if (&eligible) begin
      // Conflict: B under fixed priority, otherwise whoever did not go last.
      sel_c = (FIXED_PRIORITY != 0) ? PORT_B : ~last_grant;
    end else begin
      sel_c = eligible[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port register memory.
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   a_port, b_port           : requester handshakes (A = core, B = loader)
//   b_lock_i                 : loader lock, keeps ownership with B while high
//   mem_*_o / mem_data_i     : memory enables, address, write data, read data
//   busy_o                   : high while an access is in flight
// Each access is a one-cycle ACCESS phase (enables driven, gnt pulsed),
// followed for reads by a one-cycle RESP phase carrying rvalid.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH       = DEFAULT_REGISTER_WIDTH,
  parameter int unsigned MEMORY_ADDRESS_WIDTH = DEFAULT_MEMORY_ADDRESS_WIDTH,
  parameter int unsigned FIXED_PRIORITY       = 0
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  mem_arbiter_if.slave                    a_port,
  mem_arbiter_if.slave                    b_port,
  input  logic                            b_lock_i,
  output logic                            mem_write_en_o,
  output logic                            mem_read_en_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [REGISTER_WIDTH-1:0]       mem_data_o,
  input  logic [REGISTER_WIDTH-1:0]       mem_data_i,
  output logic                            busy_o
);

  state_e state;
  logic   sel_q;
  logic   we_q;
  logic   last_grant;
  logic   lock_owner;

  logic                            win_valid_c;
  logic                            win_sel_c;
  logic                            win_we_c;
  logic [MEMORY_ADDRESS_WIDTH-1:0] win_addr_c;
  logic [REGISTER_WIDTH-1:0]       win_wdata_c;

  rr_arbiter_2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_rr_arbiter_2 (
    .req       ({b_port.req, a_port.req}),
    .last_grant(last_grant),
    .lock_owner(lock_owner),
    .valid_c   (win_valid_c),
    .sel_c     (win_sel_c)
  );

  // Request fields of the winning port.
  always_comb begin
    win_we_c    = a_port.we;
    win_addr_c  = a_port.addr;
    win_wdata_c = a_port.wdata;
    if (win_sel_c == PORT_B) begin
      win_we_c    = b_port.we;
      win_addr_c  = b_port.addr;
      win_wdata_c = b_port.wdata;
    end
  end

  // Sequencer; memory-side and grant outputs are loaded one edge ahead so
  // they are valid throughout the ACCESS cycle and zero elsewhere.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state          <= IDLE;
      sel_q          <= PORT_A;
      we_q           <= 1'b0;
      last_grant     <= PORT_B;
      lock_owner     <= 1'b0;
      busy_o         <= 1'b0;
      mem_write_en_o <= 1'b0;
      mem_read_en_o  <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      a_port.gnt     <= 1'b0;
      b_port.gnt     <= 1'b0;
      a_port.rvalid  <= 1'b0;
      b_port.rvalid  <= 1'b0;
      a_port.rdata   <= '0;
      b_port.rdata   <= '0;
    end else begin
      mem_write_en_o <= 1'b0;
      mem_read_en_o  <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      a_port.gnt     <= 1'b0;
      b_port.gnt     <= 1'b0;
      a_port.rvalid  <= 1'b0;
      b_port.rvalid  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (win_valid_c) begin
            state          <= ACCESS;
            busy_o         <= 1'b1;
            sel_q          <= win_sel_c;
            we_q           <= win_we_c;
            last_grant     <= win_sel_c;
            mem_addr_o     <= win_addr_c;
            mem_write_en_o <= win_we_c;
            mem_read_en_o  <= ~win_we_c;
            mem_data_o     <= win_we_c ? win_wdata_c : '0;
            if (win_sel_c == PORT_B) begin
              b_port.gnt <= 1'b1;
            end else begin
              a_port.gnt <= 1'b1;
            end
          end
          // Lock is taken only together with a B grant, released whenever
          // the loader drops it while we are idle.
          if (win_valid_c && (win_sel_c == PORT_B) && b_lock_i) begin
            lock_owner <= 1'b1;
          end else if (!b_lock_i) begin
            lock_owner <= 1'b0;
          end
        end

        ACCESS: begin
          if (we_q) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            state <= RESP;
            if (sel_q == PORT_B) begin
              b_port.rdata  <= mem_data_i;
              b_port.rvalid <= 1'b1;
            end else begin
              a_port.rdata  <= mem_data_i;
              a_port.rvalid <= 1'b1;
            end
          end
        end

        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance, each
// with its own memory, driven by directed and random requests and compared
// every cycle against a transaction-schedule reference model.
module tb_mem_arbiter;

  localparam int NCYC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic mem_load;

  logic       req_d   [2][2];
  logic       we_d    [2][2];
  logic [3:0] addr_d  [2][2];
  logic [3:0] wdata_d [2][2];
  logic       lock_d  [2];

  logic       gnt_o [2][2];
  logic       rv_o  [2][2];
  logic [3:0] rd_o  [2][2];
  logic       mwe [2];
  logic       mre [2];
  logic       busy [2];
  logic [3:0] maddr [2];
  logic [3:0] mdata [2];
  logic [3:0] mrd [2];
  logic [3:0] tb_mem [2][16];

  mem_arbiter_if #(.AW(4), .DW(4)) if_a0 ();
  mem_arbiter_if #(.AW(4), .DW(4)) if_b0 ();
  mem_arbiter_if #(.AW(4), .DW(4)) if_a1 ();
  mem_arbiter_if #(.AW(4), .DW(4)) if_b1 ();

  assign if_a0.req = req_d[0][0]; assign if_a0.we = we_d[0][0];
  assign if_a0.addr = addr_d[0][0]; assign if_a0.wdata = wdata_d[0][0];
  assign if_b0.req = req_d[0][1]; assign if_b0.we = we_d[0][1];
  assign if_b0.addr = addr_d[0][1]; assign if_b0.wdata = wdata_d[0][1];
  assign if_a1.req = req_d[1][0]; assign if_a1.we = we_d[1][0];
  assign if_a1.addr = addr_d[1][0]; assign if_a1.wdata = wdata_d[1][0];
  assign if_b1.req = req_d[1][1]; assign if_b1.we = we_d[1][1];
  assign if_b1.addr = addr_d[1][1]; assign if_b1.wdata = wdata_d[1][1];

  assign gnt_o[0][0] = if_a0.gnt; assign rv_o[0][0] = if_a0.rvalid; assign rd_o[0][0] = if_a0.rdata;
  assign gnt_o[0][1] = if_b0.gnt; assign rv_o[0][1] = if_b0.rvalid; assign rd_o[0][1] = if_b0.rdata;
  assign gnt_o[1][0] = if_a1.gnt; assign rv_o[1][0] = if_a1.rvalid; assign rd_o[1][0] = if_a1.rdata;
  assign gnt_o[1][1] = if_b1.gnt; assign rv_o[1][1] = if_b1.rvalid; assign rd_o[1][1] = if_b1.rdata;

  mem_arbiter #(
    .REGISTER_WIDTH(4), .MEMORY_ADDRESS_WIDTH(4), .FIXED_PRIORITY(0)
  ) dut_rr (
    .clk_i(clk), .reset_ni(reset_n), .a_port(if_a0), .b_port(if_b0),
    .b_lock_i(lock_d[0]), .mem_write_en_o(mwe[0]), .mem_read_en_o(mre[0]),
    .mem_addr_o(maddr[0]), .mem_data_o(mdata[0]), .mem_data_i(mrd[0]),
    .busy_o(busy[0])
  );

  mem_arbiter #(
    .REGISTER_WIDTH(4), .MEMORY_ADDRESS_WIDTH(4), .FIXED_PRIORITY(1)
  ) dut_fp (
    .clk_i(clk), .reset_ni(reset_n), .a_port(if_a1), .b_port(if_b1),
    .b_lock_i(lock_d[1]), .mem_write_en_o(mwe[1]), .mem_read_en_o(mre[1]),
    .mem_addr_o(maddr[1]), .mem_data_o(mdata[1]), .mem_data_i(mrd[1]),
    .busy_o(busy[1])
  );

  // Memory power-up contents; address 0 holds 4'b1110.
  function automatic logic [3:0] init_val(input int j);
    return 4'(j) ^ 4'he;
  endfunction

  // 16x4 register memory: synchronous write, combinational read.
  assign mrd[0] = tb_mem[0][maddr[0]];
  assign mrd[1] = tb_mem[1][maddr[1]];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_load) begin
        for (int j = 0; j < 16; j++) tb_mem[i][j] <= init_val(j);
      end else if (mwe[i]) begin
        tb_mem[i][maddr[i]] <= mdata[i];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A request seen at a free edge e is granted in the cycle after e; a write
  // frees the arbiter two edges later, a read three edges later with its
  // data returned in cycle e+1.
  int         m_next [2];
  int         m_last [2];
  bit         m_lock [2];
  logic [3:0] m_mem  [2][16];
  int         gcyc   [2][2];
  bit         pend   [2][2];
  bit         f_we   [2][2];
  logic [3:0] f_addr [2][2];
  logic [3:0] f_wdata[2][2];
  logic [3:0] cur_rd [2][2];

  bit       e_gnt  [2][2][NCYC];
  bit       e_rv   [2][2][NCYC];
  bit [3:0] e_rd   [2][2][NCYC];
  bit       e_we   [2][NCYC];
  bit       e_re   [2][NCYC];
  bit       e_busy [2][NCYC];
  bit [3:0] e_addr [2][NCYC];
  bit [3:0] e_data [2][NCYC];

  bit rand_on = 0;
  bit auto_a = 0;
  bit auto_b = 0;

  task automatic model_reinit();
    for (int i = 0; i < 2; i++) begin
      m_next[i] = cyc + 1;
      m_last[i] = 1;
      m_lock[i] = 0;
      for (int p = 0; p < 2; p++) begin
        pend[i][p] = 0; gcyc[i][p] = -10; cur_rd[i][p] = 4'h0;
        req_d[i][p] = 1'b0;
      end
      for (int c = cyc; c < NCYC; c++) begin
        e_we[i][c] = 0; e_re[i][c] = 0; e_busy[i][c] = 0;
        e_addr[i][c] = 0; e_data[i][c] = 0;
        for (int p = 0; p < 2; p++) begin
          e_gnt[i][p][c] = 0; e_rv[i][p][c] = 0; e_rd[i][p][c] = 0;
        end
      end
    end
  endtask

  task automatic model_edge(input int i, input int e);
    bit ea, eb;
    int w;
    if (e < m_next[i]) return;
    ea = req_d[i][0] && !m_lock[i];
    eb = req_d[i][1];
    if (!ea && !eb) begin
      if (!lock_d[i]) m_lock[i] = 0;
      m_next[i] = e + 1;
      return;
    end
    // Instance 1 is the fixed-priority build.
    if (ea && eb) w = (i == 1) ? 1 : ((m_last[i] == 1) ? 0 : 1);
    else          w = eb ? 1 : 0;
    e_gnt[i][w][e] = 1;
    e_busy[i][e]   = 1;
    e_addr[i][e]   = f_addr[i][w];
    e_we[i][e]     = f_we[i][w];
    e_re[i][e]     = !f_we[i][w];
    e_data[i][e]   = f_we[i][w] ? f_wdata[i][w] : 4'h0;
    if (f_we[i][w]) begin
      m_mem[i][f_addr[i][w]] = f_wdata[i][w];
      m_next[i] = e + 2;
    end else begin
      e_rv[i][w][e+1] = 1;
      e_rd[i][w][e+1] = m_mem[i][f_addr[i][w]];
      e_busy[i][e+1]  = 1;
      m_next[i] = e + 3;
    end
    if (w == 1 && lock_d[i]) m_lock[i] = 1;
    else if (!lock_d[i])     m_lock[i] = 0;
    m_last[i] = w;
    gcyc[i][w] = e;
  endtask

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input int p, input bit we,
                         input logic [3:0] addr, input logic [3:0] wd);
    pend[i][p] = 1; f_we[i][p] = we; f_addr[i][p] = addr; f_wdata[i][p] = wd;
  endtask

  // Drive inputs for the next edge; a granted request is replaced only in
  // the cycle after its grant.
  task automatic plan();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[i][p] && gcyc[i][p] == cyc - 1) pend[i][p] = 0;
        if (!pend[i][p]) begin
          if ((p == 0 && auto_a) || (p == 1 && auto_b))
            set_req(i, p, 1'b0, 4'($urandom_range(0, 15)), 4'h0);
          else if (rand_on && $urandom_range(0, 99) < 35)
            set_req(i, p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
        end
        req_d[i][p]   = pend[i][p];
        we_d[i][p]    = f_we[i][p];
        addr_d[i][p]  = f_addr[i][p];
        wdata_d[i][p] = f_wdata[i][p];
      end
      if (rand_on && $urandom_range(0, 19) == 0) lock_d[i] = ~lock_d[i];
      model_edge(i, cyc + 1);
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (e_rv[i][p][cyc]) cur_rd[i][p] = e_rd[i][p][cyc];
        chk($sformatf("gnt%0d_%0d", i, p), 32'(gnt_o[i][p]), 32'(e_gnt[i][p][cyc]));
        chk($sformatf("rvalid%0d_%0d", i, p), 32'(rv_o[i][p]), 32'(e_rv[i][p][cyc]));
        chk($sformatf("rdata%0d_%0d", i, p), 32'(rd_o[i][p]), 32'(cur_rd[i][p]));
      end
      chk($sformatf("mem_we%0d", i), 32'(mwe[i]), 32'(e_we[i][cyc]));
      chk($sformatf("mem_re%0d", i), 32'(mre[i]), 32'(e_re[i][cyc]));
      chk($sformatf("mem_addr%0d", i), 32'(maddr[i]), 32'(e_addr[i][cyc]));
      chk($sformatf("mem_data%0d", i), 32'(mdata[i]), 32'(e_data[i][cyc]));
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(e_busy[i][cyc]));
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  task automatic step();
    if (cyc + 4 >= NCYC) begin
      chk("cycle_budget", 32'(cyc + 4 < NCYC), 32'd1);
      summary();
      $finish;
    end
    plan();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  function automatic bit all_idle();
    bit r = 1;
    for (int i = 0; i < 2; i++) begin
      if (m_next[i] > cyc + 1) r = 0;
      for (int p = 0; p < 2; p++) if (pend[i][p]) r = 0;
    end
    return r;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 32'(all_idle()), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_gnt%0d", tag, i), 32'({gnt_o[i][0], gnt_o[i][1]}), 32'd0);
      chk($sformatf("%s_rv%0d", tag, i), 32'({rv_o[i][0], rv_o[i][1]}), 32'd0);
      chk($sformatf("%s_rd%0d", tag, i), 32'({rd_o[i][0], rd_o[i][1]}), 32'd0);
      chk($sformatf("%s_mem%0d", tag, i), 32'({mwe[i], mre[i], maddr[i], mdata[i]}), 32'd0);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
    end
  endtask

  initial begin
    int na [2];
    int nb [2];
    int n;
    reset_n  = 1'b0;
    mem_load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lock_d[i] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        req_d[i][p] = 1'b0; we_d[i][p] = 1'b0; addr_d[i][p] = 4'h0; wdata_d[i][p] = 4'h0;
        f_we[i][p] = 1'b0; f_addr[i][p] = 4'h0; f_wdata[i][p] = 4'h0;
      end
      for (int j = 0; j < 16; j++) m_mem[i][j] = init_val(j);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    check_all_zero("reset");
    reset_n = 1'b1;
    cyc = 0;
    model_reinit();

    // First access after memory power-up: A reads address 0.
    for (int i = 0; i < 2; i++) set_req(i, 0, 1'b0, 4'h0, 4'h0);
    drain(20);
    for (int i = 0; i < 2; i++) chk($sformatf("first_read%0d", i), 32'(rd_o[i][0]), 32'h0000000e);

    // B writes A to 5 while A asks to read 5 at the same edge.
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1, 1'b1, 4'h5, 4'hA);
      set_req(i, 0, 1'b0, 4'h5, 4'h0);
    end
    drain(20);
    for (int i = 0; i < 2; i++) chk($sformatf("raw_data%0d", i), 32'(rd_o[i][0]), 32'h0000000a);

    // Both ports reading back to back.
    auto_a = 1; auto_b = 1;
    for (int i = 0; i < 2; i++) begin na[i] = 0; nb[i] = 0; end
    repeat (24) begin
      step();
      for (int i = 0; i < 2; i++) begin
        na[i] += int'(gnt_o[i][0]);
        nb[i] += int'(gnt_o[i][1]);
      end
    end
    auto_a = 0; auto_b = 0;
    chk("rr_balance", 32'((na[0] - nb[0] <= 1) && (nb[0] - na[0] <= 1)), 32'd1);
    chk("rr_progress", 32'(na[0] >= 3), 32'd1);
    chk("fixed_a_held", 32'(na[1]), 32'd0);
    chk("fixed_b_progress", 32'(nb[1] >= 6), 32'd1);
    drain(30);

    // Loader lock keeps A out until it is released.
    for (int i = 0; i < 2; i++) begin
      lock_d[i] = 1'b1;
      set_req(i, 1, 1'b1, 4'h3, 4'h7);
    end
    drain(20);
    for (int i = 0; i < 2; i++) set_req(i, 0, 1'b0, 4'h3, 4'h0);
    for (int i = 0; i < 2; i++) na[i] = 0;
    repeat (10) begin
      step();
      for (int i = 0; i < 2; i++) na[i] += int'(gnt_o[i][0]);
    end
    for (int i = 0; i < 2; i++) chk($sformatf("lock_blocks_a%0d", i), 32'(na[i]), 32'd0);
    for (int i = 0; i < 2; i++) lock_d[i] = 1'b0;
    n = 0;
    while (!gnt_o[0][0] && n < 6) begin
      step();
      n++;
    end
    chk("lock_release_latency", 32'(n), 32'd2);
    drain(20);
    for (int i = 0; i < 2; i++) chk($sformatf("lock_read%0d", i), 32'(rd_o[i][0]), 32'h00000007);

    // Random traffic with random lock activity.
    rand_on = 1;
    repeat (1500) step();
    rand_on = 0;
    for (int i = 0; i < 2; i++) lock_d[i] = 1'b0;
    drain(300);

    // Reset in the middle of an A read.
    for (int i = 0; i < 2; i++) set_req(i, 0, 1'b0, 4'h9, 4'h0);
    n = 0;
    while (!gnt_o[0][0] && n < 10) begin
      step();
      n++;
    end
    chk("mid_reset_gnt", 32'(gnt_o[0][0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk($sformatf("no_rvalid%0d", i), 32'(rv_o[i][0]), 32'd0);
    end
    reset_n = 1'b1;
    model_reinit();
    for (int i = 0; i < 2; i++) set_req(i, 0, 1'b0, 4'h9, 4'h0);
    drain(20);
    for (int i = 0; i < 2; i++)
      chk($sformatf("post_reset_read%0d", i), 32'(rd_o[i][0]), 32'(m_mem[i][9]));

    summary();
    $finish;
  end

endmodule
